// File: rtl/alu_result_writeback.sv
// alu_result_writeback: latches the ALU result into Z and sequences its write to Rc, HI/LO, MAR or PC
module alu_result_writeback #(
  parameter int WIDTH = 32,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [2*WIDTH-1:0] rc_in,
  input  logic               rf_ack,
  output logic [WIDTH-1:0]   zlo_out,
  output logic [WIDTH-1:0]   zhi_out,
  output logic               rf_en,
  output logic [WIDTH-1:0]   rf_data,
  output logic               lo_en,
  output logic               hi_en,
  output logic [WIDTH-1:0]   lo_data,
  output logic [WIDTH-1:0]   hi_data,
  output logic               mar_en,
  output logic               pc_en,
  output logic [WIDTH-1:0]   addr_data,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, WB_RC, WB_LO, WB_HI, LD_MAR, LD_PC, DONE, ERR} state_t;
  state_t state, next;
  logic [2*WIDTH-1:0] z;
  logic [CW-1:0] cnt;
  function automatic state_t dispatch(input logic [4:0] op);
    if (op inside {[5'd3:5'd13], 5'd16, 5'd17}) return WB_RC;
    if (op inside {5'd14, 5'd15}) return WB_LO;
    if (op inside {[5'd0:5'd2]}) return LD_MAR;
    return op == 5'd18 ? LD_PC : DONE;
  endfunction
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      z <= '0;
      cnt <= '0;
    end else begin
      state <= next;
      if (state == IDLE && start) z <= rc_in;
      cnt <= (state == WB_RC && next == WB_RC) ? cnt + CW'(1) : '0;
    end
  end
  always_comb begin
    next = IDLE;
    case (state)
      IDLE:          next = start ? dispatch(opcode) : IDLE;
      WB_RC:         next = rf_ack ? DONE : (cnt == LAST ? ERR : WB_RC);
      WB_LO:         next = WB_HI;
      WB_HI:         next = DONE;
      LD_MAR, LD_PC: next = DONE;
      default:       next = IDLE;
    endcase
  end
  // Moore decode: every strobe and data word comes straight from the state and Z flops
  always_comb begin
    rf_en = state == WB_RC;
    lo_en = state == WB_LO;
    hi_en = state == WB_HI;
    mar_en = state == LD_MAR;
    pc_en = state == LD_PC;
    done = state == DONE;
    err = state == ERR;
    busy = state != IDLE;
    rf_data = rf_en ? z[WIDTH-1:0] : '0;
    lo_data = lo_en ? z[WIDTH-1:0] : '0;
    hi_data = hi_en ? z[2*WIDTH-1:WIDTH] : '0;
    addr_data = (mar_en || pc_en) ? z[WIDTH-1:0] : '0;
  end
  assign zlo_out = z[WIDTH-1:0];
  assign zhi_out = z[2*WIDTH-1:WIDTH];
endmodule

// File: tb/tb_alu_result_writeback.sv
// tb_alu_result_writeback: directed and random writeback sequences checked against a per-cycle expectation model
module tb_alu_result_writeback;
  localparam int W = 32;
  localparam int TO = 15;
  logic clk = 0, clr = 1, start = 0, rf_ack = 0;
  logic [4:0] opcode = '0;
  logic [2*W-1:0] rc_in = '0;
  logic [W-1:0] zlo_out, zhi_out, rf_data, lo_data, hi_data, addr_data;
  logic rf_en, lo_en, hi_en, mar_en, pc_en, busy, done, err;
  int n_cmp = 0, n_err = 0;

  alu_result_writeback #(.WIDTH(W), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr), .start(start), .opcode(opcode), .rc_in(rc_in), .rf_ack(rf_ack),
    .zlo_out(zlo_out), .zhi_out(zhi_out), .rf_en(rf_en), .rf_data(rf_data),
    .lo_en(lo_en), .hi_en(hi_en), .lo_data(lo_data), .hi_data(hi_data),
    .mar_en(mar_en), .pc_en(pc_en), .addr_data(addr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // flags = {busy, rf_en, lo_en, hi_en, mar_en, pc_en, done, err}; data follows the flag that enables it
  task automatic chk_cycle(input string tag, input logic [7:0] f, input logic [63:0] z);
    chk({tag, ".flags"}, 64'({busy, rf_en, lo_en, hi_en, mar_en, pc_en, done, err}), 64'(f));
    chk({tag, ".rf_data"}, 64'(rf_data), f[6] ? 64'(z[31:0]) : 64'd0);
    chk({tag, ".lo_data"}, 64'(lo_data), f[5] ? 64'(z[31:0]) : 64'd0);
    chk({tag, ".hi_data"}, 64'(hi_data), f[4] ? 64'(z[63:32]) : 64'd0);
    chk({tag, ".addr"}, 64'(addr_data), (f[3] | f[2]) ? 64'(z[31:0]) : 64'd0);
    chk({tag, ".z"}, {zhi_out, zlo_out}, z);
  endtask

  // 0 = register write, 1 = mul/div, 3 = load MAR, 4 = branch, 5 = no write
  function automatic int cls(input logic [4:0] op);
    if (op inside {[5'd3:5'd13], 5'd16, 5'd17}) return 0;
    if (op == 5'd14 || op == 5'd15) return 1;
    if (op <= 5'd2) return 3;
    return op == 5'd18 ? 4 : 5;
  endfunction

  // Entered #1 after an edge with the DUT idle; ack_at = WB_RC cycle index where rf_ack rises
  task automatic run(input logic [4:0] op, input logic [63:0] rc, input int ack_at, input bit noise);
    logic [7:0] q[$];
    int c, n;
    c = cls(op);
    n = 0;
    start = 1; opcode = op; rc_in = rc; rf_ack = 1'($urandom);
    @(posedge clk); #1;
    case (c)
      0: begin
        n = ack_at < TO ? ack_at + 1 : TO;
        repeat (n) q.push_back(8'b1100_0000);
        q.push_back(ack_at < TO ? 8'b1000_0010 : 8'b1000_0001);
      end
      1: q = {8'b1010_0000, 8'b1001_0000, 8'b1000_0010};
      3: q = {8'b1000_1000, 8'b1000_0010};
      4: q = {8'b1000_0100, 8'b1000_0010};
      default: q = {8'b1000_0010};
    endcase
    foreach (q[i]) begin
      chk_cycle($sformatf("op%0d.c%0d", op, i), q[i], rc);
      start = noise ? 1'($urandom) : 1'b0;
      opcode = 5'($urandom);
      rc_in = {$urandom, $urandom};
      rf_ack = (c == 0 && i < n) ? (i >= ack_at) : 1'($urandom);
      @(posedge clk); #1;
    end
    start = 0;
    chk_cycle($sformatf("op%0d.idle", op), 8'd0, rc);
  endtask

  initial begin
    logic [63:0] r;
    #12;
    chk_cycle("reset", 8'd0, 64'd0);
    clr = 0;
    @(posedge clk); #1;
    run(5'd3, 64'h0000_0000_0000_0025, 0, 0);
    run(5'd14, 64'hFFFF_FFFE_0000_0004, 0, 0);
    run(5'd3, {$urandom, $urandom}, 100, 0);
    run(5'd4, {$urandom, $urandom}, TO - 1, 0);
    run(5'd17, {$urandom, $urandom}, 3, 0);
    run(5'd18, 64'h1234_5678_0000_0040, 0, 0);
    run(5'd25, {$urandom, $urandom}, 0, 0);
    run(5'd15, 64'hA5A5_0001_C3C3_0002, 0, 1);
    run(5'd0, {$urandom, $urandom}, 0, 1);
    run(5'd2, {$urandom, $urandom}, 0, 1);
    r = 64'hDEAD_BEEF_0BAD_F00D;
    start = 1; opcode = 5'd14; rc_in = r;
    @(posedge clk); #1;
    start = 0;
    chk_cycle("pre_clr", 8'b1010_0000, r);
    #2 clr = 1;
    #1 chk_cycle("clr_async", 8'd0, 64'd0);
    #1 clr = 0;
    @(posedge clk); #1;
    chk_cycle("after_clr", 8'd0, 64'd0);
    run(5'd8, {$urandom, $urandom}, 1, 0);
    for (int k = 0; k < 40; k++)
      run(5'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 17)), 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
